// File: rtl/prio_enc_scan.sv
// -----------------------------------------------------------------------------
// prio_enc_scan
//   Registered, glitch-filtered priority encoder that drives a time-multiplexed
//   multi-digit seven-segment display.
//
//   The switch vector is sampled every cycle. It is accepted into sw_stb only
//   after it has held the same value for STABLE_CYC+1 consecutive samples. The
//   index of the highest set bit of sw_stb is registered on y, and valid is
//   registered beside it. chg pulses for one cycle whenever {valid, y} changes.
//   A scanner steps through the hex digits of y, one digit every SCAN_DIV
//   cycles, and produces active-low segment and anode patterns.
//
//   Optional feature macro: HOLD_LAST_EN
//     When the macro is defined and en is high, y keeps its last value after
//     sw_stb returns to zero, and the display keeps showing that value. valid
//     still drops to 0. Driving en low still forces y to 0 and blanks the
//     display.
//
// Ports
//   clk    in   1       system clock, rising edge
//   rst    in   1       synchronous active-high reset
//   sw     in   N_IN    request vector, bit N_IN-1 has the highest priority
//   en     in   1       encoder enable; this input is not filtered
//   y      out  OUT_W   index of the highest set bit of the filtered vector
//   valid  out  1       en high and the filtered vector is nonzero
//   chg    out  1       one-cycle pulse when {valid, y} changes
//   seg    out  7       segments {g..a}, active-low
//   an     out  DIGITS  digit select, one-hot, active-low
// -----------------------------------------------------------------------------
module prio_enc_scan #(
    parameter int N_IN       = 16,
    parameter int STABLE_CYC = 4,
    parameter int DIGITS     = 2,
    parameter int SCAN_DIV   = 1000,
    localparam int OUT_W     = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   sw,
    input  logic              en,
    output logic [OUT_W-1:0]  y,
    output logic              valid,
    output logic              chg,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Hex digit to active-high segment pattern {g..a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            4'hF:    p = 7'h71;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    logic [N_IN-1:0]     r_sw_q;
    logic [N_IN-1:0]     r_sw_stb;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_y;
    logic                r_valid;
    logic                r_show;    // display shows r_y rather than blank
    logic                r_chg;
    logic [DIV_W-1:0]    r_div;
    logic [DIG_W-1:0]    r_dig;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic [OUT_W-1:0]    w_idx;
    logic                w_nxt_valid;
    logic [OUT_W-1:0]    w_nxt_y;
    logic                w_nxt_show;
    logic [4*DIGITS-1:0] w_num;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_onehot;

    // Input filter: a vector is accepted once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_q   <= '0;
            r_sw_stb <= '0;
            r_cnt    <= '0;
        end else begin
            r_sw_q <= sw;
            if (sw != r_sw_q) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_W'(STABLE_CYC)) begin
                r_cnt <= r_cnt + CNT_W'(1);
                // Load exactly on the STABLE_CYC-1 -> STABLE_CYC step.
                if (r_cnt == CNT_W'(STABLE_CYC - 1)) begin
                    r_sw_stb <= r_sw_q;
                end else begin
                    r_sw_stb <= r_sw_stb;
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Priority search: the last set bit scanned is the highest one.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_sw_stb[i]) begin
                w_idx = OUT_W'(i);
            end else begin
                w_idx = w_idx;
            end
        end
    end

    // Next encoder state; en low always wins over the code.
    always_comb begin
        w_nxt_valid = en && (r_sw_stb != '0);
        w_nxt_y     = '0;
        w_nxt_show  = 1'b0;
        if (w_nxt_valid) begin
            w_nxt_y    = w_idx;
            w_nxt_show = 1'b1;
        end else if (en) begin
`ifdef HOLD_LAST_EN
            w_nxt_y    = r_y;
            w_nxt_show = r_show;
`else
            w_nxt_y    = '0;
            w_nxt_show = 1'b0;
`endif
        end else begin
            w_nxt_y    = '0;
            w_nxt_show = 1'b0;
        end
    end

    // Encoder registers and the change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_valid <= 1'b0;
            r_show  <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_y     <= w_nxt_y;
            r_valid <= w_nxt_valid;
            r_show  <= w_nxt_show;
            r_chg   <= ({w_nxt_valid, w_nxt_y} != {r_valid, r_y});
        end
    end

    // Digit nibble of y zero-extended to the display width, plus anode one-hot.
    always_comb begin
        w_num = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (i < 4 * DIGITS) begin
                w_num[i] = r_y[i];
            end else begin
                w_num = w_num;
            end
        end
        w_nib = w_num[4*r_dig +: 4];
        for (int k = 0; k < DIGITS; k++) begin
            w_onehot[k] = (r_dig == DIG_W'(k));
        end
    end

    // Scanner and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_dig <= '0;
            r_an  <= ~DIGITS'(1);
            r_seg <= 7'h7F;
        end else begin
            if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                r_div <= '0;
                r_dig <= (r_dig == DIG_W'(DIGITS - 1)) ? '0 : r_dig + DIG_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
                r_dig <= r_dig;
            end
            r_an  <= ~w_onehot;
            r_seg <= r_show ? ~hex7(w_nib) : 7'h7F;
        end
    end

    assign y     = r_y;
    assign valid = r_valid;
    assign chg   = r_chg;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule
